conway_life16: RTL and testbench
================================

// Module: conway_life16
// PURPOSE
//  Conway's Game of Life engine on a toroidal grid (16x16 by default).
//  Loads a full board in one cycle, then advances one generation per clock.
//  All cells update in parallel every cycle.
//  Standalone compute block driving a display or checker from q.
// PARAMETERS
//  ROWS  16  grid rows; row r occupies bits [r*COLS +: COLS]
//  COLS  16  grid columns; bit index = r*COLS + c, col 0 = LSB of the row
// PORTS
//  clk       in   1          single clock, all logic on posedge
//  reset     in   1          synchronous, active-high; clears board
//  load      in   1          load data into board this edge (no evolution)
//  data      in   ROWS*COLS  board image to load
//  q         out  ROWS*COLS  current board, registered; 1 = live cell
//  gen_count out  16         generations since last load/reset (LIFE_GEN_COUNT_EN only)
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-high.
//  - Priority on each posedge: reset > load > evolve.
//  - reset: q <= 0 (and gen_count <= 0).
//  - load: q <= data; gen_count <= 0.
//  - Otherwise q advances exactly one generation.
//  - Latency: loaded board is visible on q 1 cycle after load.
//    The first evolved generation is visible 1 cycle after load deasserts.
//  - Neighbours: the 8 surrounding cells, wrapping on a torus.
//    Row -1 -> ROWS-1, row ROWS -> 0; same for columns.
//    No edge cells are treated as dead.
//  - Next state from live-neighbour count n (0..8, count >= 4 bits wide):
//    n<=1 -> dead; n==2 -> keep current; n==3 -> live; n>=4 -> dead.
//  - All next states are computed from the old q; no in-place partial updates.
//  - Load held high: q tracks data every cycle, no evolution.
//  - An empty board stays empty. No stall or enable input; evolution is continuous.
// CONFIGURATION
//  LIFE_GEN_COUNT_EN defined:
//    - gen_count port exists.
//    - Increments by 1 on every evolve edge; wraps 0xFFFF -> 0.
//    - Cleared by reset or load.
//  LIFE_GEN_COUNT_EN undefined:
//    - gen_count port and counter are absent.
//    - Board behaviour is identical.
// TESTING
//  1 reset=1 one edge with load=1, data=all ones -> q==0.
//    Then idle 5 cycles -> q stays 0.
//  2 Blinker: load bits {84,85,86} (row5 cols4-6).
//    -> next gen q = bits {69,85,101}.
//    -> following gen q = bits {84,85,86} again (period 2).
//  3 Wrapped block: load bits {0,15,240,255} (four corners).
//    -> q unchanged for 10 gens (requires torus wrap).
//  4 Closed diagonal: load bits r*17 for r=0..15 (bits 0,17,...,255).
//    -> stable for 10 gens (each cell has exactly 2 neighbours).
//  5 Glider: load bits {1,18,32,33,34}.
//    -> after 64 gens q equals the loaded image (diagonal wrap).
//    -> gen_count==64 when LIFE_GEN_COUNT_EN is defined.
//  6 load held 3 cycles with changing data -> q equals each data 1 cycle later.
//    Deasserting load mid-run, then reasserting it, reloads and clears gen_count.

Source files
------------

// File: rtl/conway_life16.sv
// -----------------------------------------------------------------------------
// conway_life16
//
// Purpose:
//   Conway's Game of Life engine on a toroidal ROWS x COLS grid. A full board
//   is loaded in one cycle, after which the board advances one generation on
//   every clock edge. All cells update in parallel from the previous board.
//
// Ports:
//   clk        in   1          single clock, all state on posedge
//   reset      in   1          synchronous, active-high; clears the board
//   load       in   1          capture data into the board on this edge
//   data       in   ROWS*COLS  board image to load (bit r*COLS+c = row r, col c)
//   q          out  ROWS*COLS  registered current board, 1 = live cell
//   gen_count  out  16         generations since last load/reset
//                              (present only when LIFE_GEN_COUNT_EN is defined)
//
// Configuration macro:
//   LIFE_GEN_COUNT_EN  -- adds the gen_count port and its 16-bit counter.
//                         Board behaviour is identical either way.
//
// Edge priority: reset > load > evolve.
// -----------------------------------------------------------------------------
module conway_life16 #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] data,
`ifdef LIFE_GEN_COUNT_EN
  output logic [15:0]          gen_count,
`endif
  output logic [ROWS*COLS-1:0] q
);

  localparam int NCELLS = ROWS * COLS;

  logic [NCELLS-1:0] board_q;
  logic [NCELLS-1:0] board_d;
  logic [NCELLS-1:0] evolved;

  // ---------------------------------------------------------------------------
  // Per-cell next-state logic. Every cell looks only at board_q, so the whole
  // grid moves one generation at once with no partial in-place update.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCELLS; gi++) begin : g_cell
      localparam int R  = gi / COLS;
      localparam int C  = gi % COLS;
      // Torus wrap: row -1 is ROWS-1, row ROWS is 0; same for columns.
      localparam int RU = (R + ROWS - 1) % ROWS;
      localparam int RD = (R + 1) % ROWS;
      localparam int CL = (C + COLS - 1) % COLS;
      localparam int CR = (C + 1) % COLS;

      logic [3:0] n_live;

      assign n_live = {3'b000, board_q[RU*COLS + CL]}
                    + {3'b000, board_q[RU*COLS + C ]}
                    + {3'b000, board_q[RU*COLS + CR]}
                    + {3'b000, board_q[R *COLS + CL]}
                    + {3'b000, board_q[R *COLS + CR]}
                    + {3'b000, board_q[RD*COLS + CL]}
                    + {3'b000, board_q[RD*COLS + C ]}
                    + {3'b000, board_q[RD*COLS + CR]};

      // Birth on exactly 3, survival on 2 or 3, death otherwise.
      assign evolved[gi] = (n_live == 4'd3) ||
                           ((n_live == 4'd2) && board_q[gi]);
    end
  endgenerate

  // Load has priority over evolution; reset is applied in the register.
  always_comb begin
    board_d = evolved;
    if (load) begin
      board_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q <= '0;
    end else begin
      board_q <= board_d;
    end
  end

  assign q = board_q;

`ifdef LIFE_GEN_COUNT_EN
  // ---------------------------------------------------------------------------
  // Generation counter: counts evolve edges, wraps 0xFFFF -> 0 naturally.
  // ---------------------------------------------------------------------------
  logic [15:0] gen_count_q;
  logic [15:0] gen_count_d;

  always_comb begin
    gen_count_d = gen_count_q + 16'd1;
    if (load) begin
      gen_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_count_q <= '0;
    end else begin
      gen_count_q <= gen_count_d;
    end
  end

  assign gen_count = gen_count_q;
`endif

endmodule

// File: tb/tb_conway_life16.sv
// -----------------------------------------------------------------------------
// tb_conway_life16
//
// Directed bench for conway_life16 (16x16 torus). Expected boards are known
// Life patterns: still lifes, a blinker, and a glider with a 64-generation
// return period. gen_count is checked when LIFE_GEN_COUNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conway_life16;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int N    = ROWS * COLS;

  logic         clk;
  logic         reset;
  logic         load;
  logic [N-1:0] data;
  logic [N-1:0] q;
`ifdef LIFE_GEN_COUNT_EN
  logic [15:0]  gen_count;
`endif

  int total;
  int bad;

  conway_life16 #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (data),
`ifdef LIFE_GEN_COUNT_EN
    .gen_count (gen_count),
`endif
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a board from up to five live-cell indices (-1 = unused).
  function automatic logic [N-1:0] img5(input int a, input int b, input int c,
                                        input int d, input int e);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [N-1:0] exp);
    total++;
    assert (q === exp) else begin
      bad++;
      $error("FAIL %s q=%h exp=%h", tag, q, exp);
    end
    $display("check %s q=%h", tag, q);
  endtask

  task automatic check_gc(input string tag, input int exp);
`ifdef LIFE_GEN_COUNT_EN
    total++;
    assert (gen_count === exp[15:0]) else begin
      bad++;
      $error("FAIL %s gen_count=%0d exp=%0d", tag, gen_count, exp);
    end
    $display("check %s gen_count=%0d", tag, gen_count);
`else
    // Counter is absent in this build; nothing to compare.
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  logic [N-1:0] blink_h, blink_v, corners, diag, glider, glider4, ones;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    load  = 1'b0;
    data  = '0;

    blink_h = img5(84, 85, 86, -1, -1);
    blink_v = img5(69, 85, 101, -1, -1);
    corners = img5(0, 15, 240, 255, -1);
    glider  = img5(1, 18, 32, 33, 34);
    glider4 = img5(18, 35, 49, 50, 51);   // glider shifted by (+1,+1)
    diag    = '0;
    for (int r = 0; r < ROWS; r++) diag[r*17] = 1'b1;
    ones    = '1;

    @(negedge clk);

    // 1: reset beats load; empty board stays empty.
    reset = 1'b1; load = 1'b1; data = ones;
    step();
    check_q("reset_over_load", '0);
    check_gc("reset_gc", 0);
    reset = 1'b0; load = 1'b0; data = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_q($sformatf("empty_idle%0d", i), '0);
    end

    // 2: blinker, period 2.
    load = 1'b1; data = blink_h;
    step();
    check_q("blink_load", blink_h);
    check_gc("blink_load_gc", 0);
    load = 1'b0;
    step();
    check_q("blink_gen1", blink_v);
    step();
    check_q("blink_gen2", blink_h);
    check_gc("blink_gen2_gc", 2);

    // 3: corner block held together only by the torus wrap.
    load = 1'b1; data = corners;
    step();
    check_q("corners_load", corners);
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_q($sformatf("corners_gen%0d", i), corners);
    end

    // 4: closed diagonal, every live cell has two neighbours.
    load = 1'b1; data = diag;
    step();
    check_q("diag_load", diag);
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_q($sformatf("diag_gen%0d", i), diag);
    end

    // 5: glider returns home after 64 generations.
    load = 1'b1; data = glider;
    step();
    check_q("glider_load", glider);
    load = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 4)  check_q("glider_gen4", glider4);
      if (i == 32) check_gc("glider_gen32_gc", 32);
    end
    check_q("glider_gen64", glider);
    check_gc("glider_gen64_gc", 64);

    // 6: load held with changing data, then drop and re-assert.
    load = 1'b1; data = blink_h;
    step();
    check_q("hold_load0", blink_h);
    data = corners;
    step();
    check_q("hold_load1", corners);
    data = glider;
    step();
    check_q("hold_load2", glider);
    check_gc("hold_gc", 0);
    load = 1'b0;
    step();
    step();
    step();
    step();
    check_q("hold_run4", glider4);
    check_gc("hold_run4_gc", 4);
    load = 1'b1; data = blink_v;
    step();
    check_q("reload", blink_v);
    check_gc("reload_gc", 0);
    load = 1'b0;
    step();
    check_q("reload_gen1", blink_h);
    check_gc("reload_gen1_gc", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
